// File: rtl/uart_rx.sv
// UART receive deserializer: 16x oversampled, LSB-first data, optional parity,
// configurable stop length. Presents each word with a one-clock done strobe.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level on rx_s
// START  | counting to the middle of the start bit, rejects glitches
// DATA   | sampling data bits at mid-bit, LSB first
// PARITY | sampling the parity bit and latching the mismatch
// STOP   | waiting out the stop bit(s), then publishing the word
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rx,
  input  logic                  i_s_tick,
  output logic                  o_rx_done_tick,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_frame_err,
  output logic                  o_parity_err
);

  localparam int NW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [4:0]              s_cnt_q, s_cnt_d;
  logic [NW-1:0]           n_cnt_q, n_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    p_err_q, p_err_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ferr_q, ferr_d;
  logic                    perr_q, perr_d;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state and output computation; all counters move only on a tick.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    p_err_d = p_err_q;
    done_d  = 1'b0;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = 5'd0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_cnt_q == 5'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = 5'd0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_cnt_q == 5'd15) begin
            s_cnt_d = 5'd0;
            shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            if (n_cnt_q == NW'(DATA_WIDTH-1)) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (i_s_tick) begin
          if (s_cnt_q == 5'd15) begin
            p_err_d = ((^shift_q) ^ rx_s_q) != 1'(PARITY_ODD);
            s_cnt_d = 5'd0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_cnt_q == 5'(SB_TICK-1)) begin
            state_d = IDLE;
            s_cnt_d = 5'd0;
            done_d  = 1'b1;
            data_d  = shift_q;
            ferr_d  = ~rx_s_q;
            perr_d  = (PARITY_EN != 0) ? p_err_q : 1'b0;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      s_cnt_q <= 5'd0;
      n_cnt_q <= '0;
      shift_q <= '0;
      p_err_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shift_q <= shift_d;
      p_err_q <= p_err_d;
      done_q  <= done_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign o_rx_done_tick = done_q;
  assign o_data         = data_q;
  assign o_frame_err    = ferr_q;
  assign o_parity_err   = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (plain 8N1, even parity, two stop bits)
// fed from bit-level frame drivers, with every done strobe captured and
// compared against expected words from a table or a frame-level model.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_s_tick;
  logic [2:0] rx;

  logic       done0, done1, done2;
  logic [7:0] data0, data1, data2;
  logic       ferr0, ferr1, ferr2;
  logic       perr0, perr1, perr2;

  int total = 0;
  int bad   = 0;
  int width_err = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } cap_t;

  cap_t capq[$];
  cap_t expq[$];

  typedef struct {
    int         dut;
    logic [7:0] d;
    logic       pbit;
    logic       stop_lvl;
    logic [7:0] ed;
    logic       ef;
    logic       ep;
  } vec_t;

  vec_t tbl[6];

  uart_rx #(.DATA_WIDTH(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx(rx[0]), .i_s_tick(i_s_tick),
    .o_rx_done_tick(done0), .o_data(data0), .o_frame_err(ferr0), .o_parity_err(perr0));

  uart_rx #(.DATA_WIDTH(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx(rx[1]), .i_s_tick(i_s_tick),
    .o_rx_done_tick(done1), .o_data(data1), .o_frame_err(ferr1), .o_parity_err(perr1));

  uart_rx #(.DATA_WIDTH(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx(rx[2]), .i_s_tick(i_s_tick),
    .o_rx_done_tick(done2), .o_data(data2), .o_frame_err(ferr2), .o_parity_err(perr2));

  always #5 i_clk = ~i_clk;

  // Oversampling tick: one clock high out of every four.
  initial begin
    i_s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge i_clk);
      #1 i_s_tick = 1'b1;
      @(posedge i_clk);
      #1 i_s_tick = 1'b0;
    end
  end

  // Capture every done strobe and flag any strobe longer than one clock.
  always @(negedge i_clk) begin
    if (done0) capq.push_back(cap_t'{2'd0, data0, ferr0, perr0});
    if (done1) capq.push_back(cap_t'{2'd1, data1, ferr1, perr1});
    if (done2) capq.push_back(cap_t'{2'd2, data2, ferr2, perr2});
    if ((done0 && prev0) || (done1 && prev1) || (done2 && prev2)) width_err++;
    prev0 = done0;
    prev1 = done1;
    prev2 = done2;
  end

  task automatic wclk(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // One frame at 64 clocks per bit; a bad stop is low for the first 3/4 of the bit.
  task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stop_lvl, input int nstop);
    rx[which] = 1'b0;
    wclk(64);
    for (int i = 0; i < 8; i++) begin
      rx[which] = d[i];
      wclk(64);
    end
    if (has_par) begin
      rx[which] = pbit;
      wclk(64);
    end
    if (stop_lvl) begin
      rx[which] = 1'b1;
      wclk(64 * nstop);
    end else begin
      rx[which] = 1'b0;
      wclk(48);
      rx[which] = 1'b1;
      wclk(16 + 64 * (nstop - 1));
    end
  endtask

  // Frame-level reference: word as sent, frame error from the stop level,
  // parity error when the count of ones over data+parity is odd (even parity on dut1).
  function automatic cap_t model(input int dut, input logic [7:0] d, input logic pbit,
                                 input logic stop_lvl);
    cap_t c;
    c.dut  = 2'(dut);
    c.data = d;
    c.ferr = !stop_lvl;
    c.perr = (dut == 1) ? (($countones({d, pbit}) % 2) != 0) : 1'b0;
    return c;
  endfunction

  task automatic check_caps(input string name);
    cap_t c, e;
    total++;
    if (capq.size() != expq.size()) begin
      bad++;
      $display("FAIL %s done_count got=%0d want=%0d", name, capq.size(), expq.size());
    end
    while (capq.size() > 0 && expq.size() > 0) begin
      c = capq.pop_front();
      e = expq.pop_front();
      total++;
      if (c !== e) begin
        bad++;
        $display("FAIL %s frame got dut=%0d data=%h ferr=%b perr=%b want dut=%0d data=%h ferr=%b perr=%b",
                 name, c.dut, c.data, c.ferr, c.perr, e.dut, e.data, e.ferr, e.perr);
      end
    end
    capq.delete();
    expq.delete();
  endtask

  task automatic check_zero(input string name);
    logic [32:0] got;
    got = {done0, data0, ferr0, perr0, done1, data1, ferr1, perr1, done2, data2, ferr2, perr2};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s outputs got=%h want=0", name, got);
    end
  endtask

  initial begin
    logic changed;
    int   dut;
    logic [7:0] d;
    logic pbit, stop_lvl;

    tbl[0] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[1] = '{0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[2] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    tbl[4] = '{1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};

    rx = 3'b111;
    i_reset_n = 1'b0;
    wclk(3);
    check_zero("reset_state");
    i_reset_n = 1'b1;
    wclk(20);

    // Clean 0xA5, then the word must hold for 200 clocks.
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
    expq.push_back(model(0, 8'hA5, 1'b0, 1'b1));
    check_caps("a5_frame");
    changed = 1'b0;
    for (int i = 0; i < 200; i++) begin
      wclk(1);
      if (data0 !== 8'hA5) changed = 1'b1;
    end
    total++;
    if (changed) begin
      bad++;
      $display("FAIL a5_hold data changed got=%h want=a5", data0);
    end

    // Five-tick low glitch: no strobe, outputs untouched.
    rx[0] = 1'b0;
    wclk(20);
    rx[0] = 1'b1;
    wclk(300);
    check_caps("glitch");
    total++;
    if ({data0, ferr0, perr0} !== {8'hA5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL glitch_hold got data=%h ferr=%b perr=%b want data=a5 ferr=0 perr=0",
               data0, ferr0, perr0);
    end

    // Table vectors: framing and parity cases with hand-derived expectations.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dut, tbl[i].d, tbl[i].dut == 1, tbl[i].pbit, tbl[i].stop_lvl, 1);
      expq.push_back(cap_t'{2'(tbl[i].dut), tbl[i].ed, tbl[i].ef, tbl[i].ep});
      wclk(64);
      check_caps($sformatf("vec%0d", i));
    end

    // Reset in the middle of a 0xFF frame.
    rx[0] = 1'b0;
    wclk(64);
    rx[0] = 1'b1;
    wclk(64 * 3 + 20);
    i_reset_n = 1'b0;
    #2;
    check_zero("async_reset");
    wclk(30);
    check_zero("held_reset");
    i_reset_n = 1'b1;
    wclk(700);
    check_caps("aborted_frame");
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1);
    expq.push_back(model(0, 8'h81, 1'b0, 1'b1));
    check_caps("after_reset");

    // Back-to-back frames with two stop bits and no idle gap.
    send_frame(2, 8'h01, 1'b0, 1'b0, 1'b1, 2);
    send_frame(2, 8'h80, 1'b0, 1'b0, 1'b1, 2);
    send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 2);
    expq.push_back(model(2, 8'h01, 1'b0, 1'b1));
    expq.push_back(model(2, 8'h80, 1'b0, 1'b1));
    expq.push_back(model(2, 8'hFF, 1'b0, 1'b1));
    wclk(64);
    check_caps("back_to_back");

    // Random frames against the frame-level model.
    for (int i = 0; i < 20; i++) begin
      dut      = int'($urandom_range(0, 1));
      d        = 8'($urandom);
      pbit     = 1'($urandom);
      stop_lvl = ($urandom_range(0, 3) != 0);
      send_frame(dut, d, dut == 1, pbit, stop_lvl, 1);
      expq.push_back(model(dut, d, pbit, stop_lvl));
      wclk(stop_lvl ? int'($urandom_range(0, 80)) : int'($urandom_range(64, 120)));
    end
    wclk(64);
    check_caps("random");

    total++;
    if (width_err != 0) begin
      bad++;
      $display("FAIL done_width long pulses got=%0d want=0", width_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive deserializer. It oversamples the serial line at 16 ticks per bit, recovers one frame (start, data LSB-first, optional parity, stop) and presents the word for one clock with a done strobe. It sits directly upstream of the receive flag buffer: o_rx_done_tick drives the buffer's set-flag input and o_data drives its data input. The baud-rate generator supplies i_s_tick.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
SB_TICK, 16, oversampling ticks for the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2).
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected (ignored when PARITY_EN = 0).

Ports:
i_clk  input  1  system clock, all state on rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_rx  input  1  asynchronous serial line, idle high.
i_s_tick  input  1  oversampling enable, one-clock pulse at 16x baud.
o_rx_done_tick  output  1  one-clock pulse when a frame completes.
o_data  output  DATA_WIDTH  last received word.
o_frame_err  output  1  stop bit sampled low in the last frame.
o_parity_err  output  1  parity mismatch in the last frame.

Behaviour:
- Reset (i_reset_n = 0, asynchronous, any state, including mid-frame):
  - FSM goes to IDLE.
  - Tick counter, bit counter and shift register cleared.
  - Synchronizer flops set to 1.
  - All outputs 0.
- Input sync: i_rx passes through a 2-FF synchronizer. The FSM only samples the synchronized value rx_s.
- Counters: s_cnt is 0..SB_TICK-1, 5 bits. n_cnt is 0..DATA_WIDTH-1, width clog2(DATA_WIDTH). Counters advance only on clocks where i_s_tick = 1; with no tick, all state holds.
- IDLE:
  - rx_s = 0 -> START, s_cnt = 0. This transition does not wait for a tick.
- START, on a tick:
  - s_cnt = 7 and rx_s = 0 -> DATA, s_cnt = 0, n_cnt = 0.
  - s_cnt = 7 and rx_s = 1 -> IDLE (glitch reject). No strobe, error outputs unchanged.
  - Otherwise s_cnt++.
- DATA, on a tick:
  - s_cnt = 15 -> s_cnt = 0, shift_reg = {rx_s, shift_reg[DATA_WIDTH-1:1]} (LSB first).
  - If n_cnt = DATA_WIDTH-1 at that sample, go to PARITY when PARITY_EN = 1, else STOP. Otherwise n_cnt++.
  - Otherwise s_cnt++.
- PARITY, on a tick:
  - s_cnt = 15 -> latch p_err = (^shift_reg ^ rx_s) != PARITY_ODD, s_cnt = 0, go to STOP.
  - Otherwise s_cnt++.
- STOP, on a tick:
  - s_cnt = SB_TICK-1 -> go to IDLE, and on the same edge:
    - o_rx_done_tick = 1 for exactly one clock.
    - o_data = shift_reg.
    - o_frame_err = ~rx_s.
    - o_parity_err = p_err, or 0 when PARITY_EN = 0.
  - Otherwise s_cnt++.
- Output holding: o_data, o_frame_err and o_parity_err are registered and change only on the done edge. They hold until the next done. The strobe fires even when an error flag is set; the consumer decides whether to use the word.
- Line held low (break): each full frame time yields done with o_frame_err = 1 and o_data = 0. IDLE then re-enters START at once because rx_s is still low.
- Back-to-back frames: a new start edge seen in the clock after STOP -> IDLE is accepted. No idle gap is required.
- Latency: the done edge falls 2 clocks (synchronizer) after the tick that completes the stop bit, relative to the line. No done pulse ever lasts more than 1 clock, even if i_s_tick is held high.
- Tick slip: ticks coinciding with reset release are ignored.

Test Plan:
- Bench setup for all scenarios: i_s_tick every 4 clk, DATA_WIDTH = 8, PARITY_EN = 0, unless stated.
- Send 0xA5, 1 stop bit -> exactly one o_rx_done_tick pulse, o_data = 0xA5, o_frame_err = 0, o_parity_err = 0. o_data stays 0xA5 for 200 clk afterwards.
- Low pulse on i_rx lasting 5 ticks, then high -> FSM returns to IDLE, no done pulse, outputs unchanged from previous frame.
- Send 0x3C with stop bit forced low, then line high -> done pulse with o_data = 0x3C, o_frame_err = 1. A following clean 0x55 frame -> o_data = 0x55, o_frame_err = 0.
- PARITY_EN = 1, PARITY_ODD = 0: send 0x07 with parity bit 1 -> o_parity_err = 0. Send 0x07 with parity bit 0 -> o_parity_err = 1, done still pulses.
- Assert i_reset_n = 0 mid-data of 0xFF, release, then send 0x81 -> all outputs 0 during reset. No done for the aborted frame. Next done gives o_data = 0x81.
- Back-to-back 0x01, 0x80, 0xFF with zero idle gap and SB_TICK = 32 -> three done pulses, o_data sequence 0x01, 0x80, 0xFF, no errors.
